// File: rtl/address_gen_unit.sv
`default_nettype none
// ============================================================================
// Module  : address_gen_unit
// Purpose : Registered address generator for the 65c02 core. Selects the
//           PC / stack / absolute / indexed / increment address, adds the
//           index with page-cross detection and performs the high-byte
//           fix-up cycle in hardware.
// Ports   : phi2, resb          clock, async active-low reset
//           be, rdy             output enable, global stall
//           cmd_valid/ready,cmd command handshake and opcode
//           force_fix           IDX: always take the fix-up cycle
//           pc_in, sp_in        program counter, stack pointer
//           base_hi, base_lo    operand latches
//           index_in            X or Y
//           addr_out            registered address, high-Z when be=0
//           addr_valid          address register holds an accepted result
//           page_cross          last IDX add carried out of the low byte
//           busy                fix-up cycle pending
// Revision: 1.0 - initial release
// ============================================================================
module address_gen_unit #(
  parameter int                    ADDR_W     = 16,
  parameter logic [ADDR_W-9:0]     STACK_PAGE = 'h01,
  parameter logic [ADDR_W-1:0]     RST_ADDR   = 'hFFFC
) (
  input  logic                phi2,
  input  logic                resb,
  input  logic                be,
  input  logic                rdy,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [2:0]          cmd,
  input  logic                force_fix,
  input  logic [ADDR_W-1:0]   pc_in,
  input  logic [7:0]          sp_in,
  input  logic [ADDR_W-9:0]   base_hi,
  input  logic [7:0]          base_lo,
  input  logic [7:0]          index_in,
  output logic [ADDR_W-1:0]   addr_out,
  output logic                addr_valid,
  output logic                page_cross,
  output logic                busy
);

  localparam int HI_W = ADDR_W - 8;

  localparam logic [2:0] c_CMD_HOLD   = 3'd0;
  localparam logic [2:0] c_CMD_PC     = 3'd1;
  localparam logic [2:0] c_CMD_STACK  = 3'd2;
  localparam logic [2:0] c_CMD_ABS    = 3'd3;
  localparam logic [2:0] c_CMD_IDX    = 3'd4;
  localparam logic [2:0] c_CMD_INC    = 3'd5;
  localparam logic [2:0] c_CMD_INC_ZP = 3'd6;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_FIX  = 1'b1
  } state_t;

  state_t             r_state;
  logic [ADDR_W-1:0]  r_addr;
  logic [HI_W-1:0]    r_hi_fix;
  logic               r_valid;
  logic               r_page_cross;
  logic               r_busy;

  logic [8:0]         w_sum;
  logic               w_carry;
  logic [HI_W-1:0]    w_hi_fix;
  logic [ADDR_W-1:0]  w_inc;
  logic [7:0]         w_lo_inc;
  logic               w_accept;

  // 9-bit low-byte add; the carry drives both page_cross and the fix-up
  assign w_sum    = {1'b0, base_lo} + {1'b0, index_in};
  assign w_carry  = w_sum[8];
  assign w_hi_fix = base_hi + HI_W'(w_carry);
  assign w_inc    = r_addr + ADDR_W'(1);
  assign w_lo_inc = r_addr[7:0] + 8'd1;

  assign cmd_ready = rdy & ~r_busy;
  assign w_accept  = cmd_valid & cmd_ready;

  always_ff @(posedge phi2 or negedge resb) begin
    if (!resb) begin
      r_state      <= ST_IDLE;
      r_addr       <= RST_ADDR;
      r_hi_fix     <= '0;
      r_valid      <= 1'b0;
      r_page_cross <= 1'b0;
      r_busy       <= 1'b0;
    end else if (rdy) begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            case (cmd)
              c_CMD_PC: begin
                r_addr  <= pc_in;
                r_valid <= 1'b1;
              end
              c_CMD_STACK: begin
                r_addr  <= {STACK_PAGE, sp_in};
                r_valid <= 1'b1;
              end
              c_CMD_ABS: begin
                r_addr  <= {base_hi, base_lo};
                r_valid <= 1'b1;
              end
              c_CMD_IDX: begin
                // First cycle presents the uncorrected high part; the
                // corrected one is latched for the fix-up cycle.
                r_addr       <= {base_hi, w_sum[7:0]};
                r_valid      <= 1'b1;
                r_page_cross <= w_carry;
                r_hi_fix     <= w_hi_fix;
                if (w_carry || force_fix) begin
                  r_busy  <= 1'b1;
                  r_state <= ST_FIX;
                end
              end
              c_CMD_INC: begin
                r_addr  <= w_inc;
                r_valid <= 1'b1;
              end
              c_CMD_INC_ZP: begin
                r_addr  <= {r_addr[ADDR_W-1:8], w_lo_inc};
                r_valid <= 1'b1;
              end
              default: begin
                // HOLD and the reserved code leave everything unchanged
              end
            endcase
          end
        end
        ST_FIX: begin
          r_addr[ADDR_W-1:8] <= r_hi_fix;
          r_busy             <= 1'b0;
          r_state            <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // be only gates the pin drivers; internal state is unaffected
  assign addr_out   = be ? r_addr : {ADDR_W{1'bz}};
  assign addr_valid = r_valid;
  assign page_cross = r_page_cross;
  assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_address_gen_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_address_gen_unit
// Purpose : Self-checking bench for address_gen_unit: a vector table for the
//           main command set plus directed sequences for stalls, output
//           enable, reset during fix-up and a 20-bit address instance.
// Revision: 1.0 - initial release
// ============================================================================
module tb_address_gen_unit;

  logic        clk;
  logic        resb;
  logic        be;
  logic        rdy;
  logic        cmd_valid;
  logic [2:0]  cmd;
  logic        force_fix;
  logic [15:0] pc_in;
  logic [7:0]  sp_in;
  logic [7:0]  base_hi;
  logic [7:0]  base_lo;
  logic [7:0]  index_in;
  logic [19:0] pc_in20;
  logic [11:0] base_hi20;

  logic        cmd_ready, addr_valid, page_cross, busy;
  logic [15:0] addr_out;
  logic        cmd_ready20, addr_valid20, page_cross20, busy20;
  logic [19:0] addr_out20;

  int n_pass;
  int n_total;

  address_gen_unit #(.ADDR_W(16)) dut (
    .phi2(clk), .resb(resb), .be(be), .rdy(rdy),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
    .force_fix(force_fix), .pc_in(pc_in), .sp_in(sp_in),
    .base_hi(base_hi), .base_lo(base_lo), .index_in(index_in),
    .addr_out(addr_out), .addr_valid(addr_valid),
    .page_cross(page_cross), .busy(busy)
  );

  address_gen_unit #(.ADDR_W(20)) dut20 (
    .phi2(clk), .resb(resb), .be(be), .rdy(rdy),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready20), .cmd(cmd),
    .force_fix(force_fix), .pc_in(pc_in20), .sp_in(sp_in),
    .base_hi(base_hi20), .base_lo(base_lo), .index_in(index_in),
    .addr_out(addr_out20), .addr_valid(addr_valid20),
    .page_cross(page_cross20), .busy(busy20)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [2:0]  cmd;
    logic        ff;
    logic [15:0] pc;
    logic [7:0]  sp;
    logic [7:0]  bhi;
    logic [7:0]  blo;
    logic [7:0]  idx;
    logic [15:0] e_addr;
    logic        e_valid;
    logic        e_pc;
    logic        e_busy;
  } vec_t;

  localparam int NV = 20;
  vec_t tbl [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] c, input logic ff);
    cmd_valid = v;
    cmd       = c;
    force_fix = ff;
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    resb = 1'b0; be = 1'b1; rdy = 1'b1;
    cmd_valid = 1'b0; cmd = 3'd0; force_fix = 1'b0;
    pc_in = '0; sp_in = '0; base_hi = '0; base_lo = '0; index_in = '0;
    pc_in20 = '0; base_hi20 = '0;

    //                valid cmd  ff pc       sp     bhi    blo    idx    addr     v    pc   busy
    tbl[0]  = '{1'b1, 3'd0, 1'b0, 16'h0000, 8'h00, 8'h00, 8'h00, 8'h00, 16'hFFFC, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 3'd1, 1'b0, 16'h0400, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0400, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 3'd3, 1'b0, 16'h0000, 8'h00, 8'h12, 8'h34, 8'h00, 16'h1234, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 3'd4, 1'b0, 16'h0000, 8'h00, 8'h12, 8'h34, 8'h10, 16'h1244, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 3'd4, 1'b0, 16'h0000, 8'h00, 8'h12, 8'hF0, 8'h20, 16'h1210, 1'b1, 1'b1, 1'b1};
    tbl[5]  = '{1'b1, 3'd3, 1'b0, 16'h0000, 8'h00, 8'h55, 8'h66, 8'h00, 16'h1310, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 3'd3, 1'b0, 16'h0000, 8'h00, 8'h55, 8'h66, 8'h00, 16'h5566, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 3'd4, 1'b1, 16'h0000, 8'h00, 8'h12, 8'h34, 8'h01, 16'h1235, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 3'd0, 1'b0, 16'h0000, 8'h00, 8'h00, 8'h00, 8'h00, 16'h1235, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 3'd2, 1'b0, 16'h0000, 8'hFF, 8'h00, 8'h00, 8'h00, 16'h01FF, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 3'd1, 1'b0, 16'hFFFF, 8'h00, 8'h00, 8'h00, 8'h00, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 3'd5, 1'b0, 16'h0000, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 3'd5, 1'b0, 16'h0000, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0001, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 3'd3, 1'b0, 16'h0000, 8'h00, 8'h20, 8'hFF, 8'h00, 16'h20FF, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 3'd6, 1'b0, 16'h0000, 8'h00, 8'h00, 8'h00, 8'h00, 16'h2000, 1'b1, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 3'd7, 1'b0, 16'h9999, 8'h00, 8'h77, 8'h77, 8'h00, 16'h2000, 1'b1, 1'b0, 1'b0};
    tbl[16] = '{1'b1, 3'd4, 1'b0, 16'h0000, 8'h00, 8'hFF, 8'hF0, 8'h20, 16'hFF10, 1'b1, 1'b1, 1'b1};
    tbl[17] = '{1'b1, 3'd0, 1'b0, 16'h0000, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0010, 1'b1, 1'b1, 1'b0};
    tbl[18] = '{1'b1, 3'd6, 1'b0, 16'h0000, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0011, 1'b1, 1'b1, 1'b0};
    tbl[19] = '{1'b0, 3'd1, 1'b0, 16'h1111, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0011, 1'b1, 1'b1, 1'b0};

    // ---------------- reset ----------------
    tick(); tick();
    check("rst_addr",   32'(addr_out),   32'h0000_FFFC);
    check("rst_valid",  32'(addr_valid), 32'h0);
    check("rst_busy",   32'(busy),       32'h0);
    check("rst_pcross", 32'(page_cross), 32'h0);
    check("rst_addr20", 32'(addr_out20), 32'h0000_FFFC);
    resb = 1'b1;
    tick(); tick();
    check("rel_addr",  32'(addr_out),   32'h0000_FFFC);
    check("rel_valid", 32'(addr_valid), 32'h0);
    check("rel_ready", 32'(cmd_ready),  32'h1);

    // ---------------- vector table ----------------
    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].valid, tbl[i].cmd, tbl[i].ff);
      pc_in = tbl[i].pc; sp_in = tbl[i].sp;
      base_hi = tbl[i].bhi; base_lo = tbl[i].blo; index_in = tbl[i].idx;
      tick();
      check($sformatf("v%0d_addr", i),  32'(addr_out),   32'(tbl[i].e_addr));
      check($sformatf("v%0d_valid", i), 32'(addr_valid), 32'(tbl[i].e_valid));
      check($sformatf("v%0d_pcross", i), 32'(page_cross), 32'(tbl[i].e_pc));
      check($sformatf("v%0d_busy", i),  32'(busy),       32'(tbl[i].e_busy));
      check($sformatf("v%0d_ready", i), 32'(cmd_ready),  32'(!tbl[i].e_busy));
    end

    // ---------------- rdy stall in FIX ----------------
    drive(1'b1, 3'd4, 1'b0);
    base_hi = 8'h12; base_lo = 8'hF0; index_in = 8'h20;
    tick();
    check("stall_first", 32'(addr_out), 32'h0000_1210);
    rdy = 1'b0;
    drive(1'b1, 3'd3, 1'b0);
    base_hi = 8'hAA; base_lo = 8'hBB;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("stall%0d_addr", k),  32'(addr_out),  32'h0000_1210);
      check($sformatf("stall%0d_busy", k),  32'(busy),      32'h1);
      check($sformatf("stall%0d_ready", k), 32'(cmd_ready), 32'h0);
    end
    rdy = 1'b1;
    drive(1'b0, 3'd0, 1'b0);
    tick();
    check("stall_fix_addr", 32'(addr_out), 32'h0000_1310);
    check("stall_fix_busy", 32'(busy),     32'h0);

    // ---------------- be gating ----------------
    be = 1'b0;
    #1;
    check("be0_z", 32'(addr_out === 16'hzzzz), 32'h1);
    tick();
    be = 1'b1;
    #1;
    check("be1_addr", 32'(addr_out), 32'h0000_1310);

    // ---------------- reset in the middle of FIX ----------------
    drive(1'b1, 3'd4, 1'b0);
    base_hi = 8'h34; base_lo = 8'hFF; index_in = 8'h01;
    tick();
    check("mrst_pre_busy", 32'(busy), 32'h1);
    drive(1'b0, 3'd0, 1'b0);
    resb = 1'b0;
    #1;
    check("mrst_addr",   32'(addr_out),   32'h0000_FFFC);
    check("mrst_busy",   32'(busy),       32'h0);
    check("mrst_valid",  32'(addr_valid), 32'h0);
    check("mrst_pcross", 32'(page_cross), 32'h0);
    tick();
    resb = 1'b1;
    tick();
    check("mrst_after", 32'(addr_out), 32'h0000_FFFC);
    check("mrst_after_busy", 32'(busy), 32'h0);

    // ---------------- 20-bit instance ----------------
    drive(1'b1, 3'd1, 1'b0);
    pc_in20 = 20'hFFFFF;
    tick();
    check("w20_pc", 32'(addr_out20), 32'h000F_FFFF);
    drive(1'b1, 3'd5, 1'b0);
    tick();
    check("w20_inc_wrap", 32'(addr_out20), 32'h0000_0000);
    drive(1'b1, 3'd4, 1'b0);
    base_hi20 = 12'hFFF; base_lo = 8'hF0; index_in = 8'h20;
    tick();
    check("w20_idx1", 32'(addr_out20), 32'h000F_FF10);
    check("w20_idx1_busy", 32'(busy20), 32'h1);
    drive(1'b1, 3'd0, 1'b0);
    tick();
    check("w20_idx2", 32'(addr_out20), 32'h0000_0010);
    check("w20_idx2_busy", 32'(busy20), 32'h0);
    drive(1'b1, 3'd2, 1'b0);
    sp_in = 8'h80;
    tick();
    check("w20_stack", 32'(addr_out20), 32'h0000_0180);
    drive(1'b0, 3'd0, 1'b0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
